nf_dm_responder: RTL and testbench
==================================

// Module: nf_dm_responder
// PURPOSE
//   Data-memory responder on the CPU data port (addr_dm/wd_dm/we_dm/req_dm in, rd_dm/req_ack_dm out).
//   Accepts one load/store request at a time, inserts WAIT_CYCLES wait states, performs the access
//   on a word-addressed internal RAM, then pulses req_ack_dm for one cycle. Sits between the CPU
//   memory stage and the system bus; the CPU holds its memory stage stalled until the ack pulse.
// PARAMETERS
//   ADDR_W       10   RAM index width; DEPTH = 2**ADDR_W 32-bit words
//   WAIT_CYCLES  2    wait states between accept and ack (0 allowed)
// PORTS
//   clk         in   1   clock, all state updates on rising edge
//   reset       in   1   synchronous reset, active-high
//   addr_dm     in   32  byte address; bits [ADDR_W+1:2] index RAM, all other bits ignored
//   wd_dm       in   32  store data
//   we_dm       in   1   1 = store, 0 = load (valid while req_dm=1)
//   req_dm      in   1   request, held high by CPU until ack
//   rd_dm       out  32  load data, registered, held until next load completes
//   req_ack_dm  out  1   one-cycle acknowledge pulse, registered
//   busy        out  1   1 in WAIT or ACK
// BEHAVIOUR
//   Reset: state=IDLE, req_ack_dm=0, rd_dm=0, busy=0, wait counter=0; RAM contents not reset.
//   Reset mid-transaction: abort, pending store NOT written, no ack issued.
//   FSM IDLE/WAIT/ACK:
//   - IDLE: if req_dm=1, latch addr index, wd_dm, we_dm into internal regs (accept).
//     WAIT_CYCLES>0 -> WAIT with counter=WAIT_CYCLES-1; WAIT_CYCLES=0 -> perform access, -> ACK.
//   - WAIT: if req_dm=0 -> IDLE (abort, no access, no ack). Else if counter=0 -> perform access,
//     -> ACK; else counter decrements. Input changes other than req_dm ignored after accept.
//   - ACK: req_ack_dm=1 for exactly this cycle; -> IDLE unconditionally. req_dm still high in
//     ACK cycle is the completed request and is never re-accepted.
//   Access (on the edge entering ACK): store -> RAM[idx]<=wd latched; load -> rd_dm<=RAM[idx].
//   rd_dm valid from first cycle of ACK, unchanged by stores, held until next load's access edge.
//   Latency: req_dm seen high in IDLE at cycle 0 -> req_ack_dm high in cycle WAIT_CYCLES+1.
//   Throughput: back-to-back requests, one per WAIT_CYCLES+2 cycles (ACK->IDLE->accept).
//   Addressing: addresses differing only above bit ADDR_W+1 alias the same word (wrap);
//   addr_dm[1:0] ignored, full-word accesses only.
//   Store then load same word: load returns stored value (store completed before load accepted).
//   busy = (state != IDLE). Counter width = max(1,$clog2(WAIT_CYCLES+1)).
// TESTING
//   1 WAIT_CYCLES=2: store 0xDEADBEEF @0x10, hold req -> ack in cycle 3 only, 1-cycle pulse;
//     then load @0x10 -> ack cycle 3, rd_dm=0xDEADBEEF from ack cycle, held 5 cycles after req=0.
//   2 WAIT_CYCLES=0: load @0x4 accepted cycle 0 -> ack cycle 1; continuous req for 3 loads
//     -> acks at cycles 1,3,5, never two consecutive ack cycles.
//   3 Abort: store 0x12345678 @0x20, drop req_dm in WAIT -> no ack; later load @0x20 returns
//     previous contents (e.g. 0x0 pre-written), busy back to 0 next cycle.
//   4 Alias: ADDR_W=10, store 0xA5A5A5A5 @0x0000_1008 -> load @0x0000_0008 returns 0xA5A5A5A5;
//     load @0x0000_000B also returns 0xA5A5A5A5 (byte offset ignored).
//   5 Reset mid-WAIT during store 0xCAFEF00D @0x30 -> req_ack_dm=0, rd_dm=0, busy=0 next cycle;
//     load @0x30 afterwards does not return 0xCAFEF00D.
//   6 Input change in WAIT: accept load @0x40, switch addr_dm to 0x44 and we_dm=1 before ack
//     -> no write occurs, rd_dm = RAM[0x40 word].

Source files
------------

// File: rtl/nf_dm_responder.sv
// -----------------------------------------------------------------------------
// nf_dm_responder
//   Data-memory responder for the CPU data port. Accepts one load/store at a
//   time, waits WAIT_CYCLES cycles, performs the access on a word-addressed
//   internal RAM, then pulses req_ack_dm for one cycle. The CPU keeps its
//   memory stage stalled (req_dm held high) until it sees that pulse.
//
// Parameters
//   ADDR_W       RAM index width, RAM holds 2**ADDR_W 32-bit words
//   WAIT_CYCLES  wait states between accept and ack (0 allowed)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       synchronous reset, active-high
//   addr_dm     byte address, bits [ADDR_W+1:2] select the word
//   wd_dm       store data
//   we_dm       1 = store, 0 = load
//   req_dm      request, held high until acknowledged
//   rd_dm       registered load data, held until the next load completes
//   req_ack_dm  registered one-cycle acknowledge
//   busy        high while a request is in WAIT or ACK
// -----------------------------------------------------------------------------
module nf_dm_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_dm,
    input  logic [31:0] wd_dm,
    input  logic        we_dm,
    input  logic        req_dm,
    output logic [31:0] rd_dm,
    output logic        req_ack_dm,
    output logic        busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wd_q;
    logic              we_q;

    logic              accept;
    logic              access_en;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wd;
    logic              acc_we;

    logic [31:0]       mem [DEPTH];

    // Address bits outside the word index are deliberately ignored, which
    // makes addresses above the RAM size alias onto it.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_dm[31:ADDR_W+2], addr_dm[1:0]};

    // State register together with the registered outputs. The ack flop is
    // loaded from next_state so it is high exactly for the ACK cycle. Reset
    // drops any request in flight without acknowledging it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_ack_dm <= 1'b0;
            rd_dm      <= '0;
        end else begin
            state      <= next_state;
            cnt        <= cnt_next;
            req_ack_dm <= (next_state == ST_ACK);
            if (access_en && !acc_we) begin
                rd_dm <= mem[acc_idx];
            end
        end
    end

    // Request capture. After accept the CPU-side inputs (other than req_dm)
    // no longer matter; the access uses these copies.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q <= addr_dm[ADDR_W+1:2];
            wd_q  <= wd_dm;
            we_q  <= we_dm;
        end
    end

    // Word RAM, contents survive reset. A store that is still pending when
    // reset arrives is never written.
    always_ff @(posedge clk) begin
        if (!reset && access_en && acc_we) begin
            mem[acc_idx] <= acc_wd;
        end
    end

    // Next-state logic. With zero wait states the access happens on the same
    // edge that accepts the request, straight from the input pins. ACK always
    // returns to IDLE so a req_dm still high there is never re-accepted.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_dm) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        access_en  = 1'b1;
                        next_state = ST_ACK;
                    end else begin
                        cnt_next   = CNT_INIT;
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req_dm) begin
                    next_state = ST_IDLE;
                end else if (cnt == '0) begin
                    access_en  = 1'b1;
                    next_state = ST_ACK;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_ACK: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode and access operand select: inputs directly in IDLE
    // (zero-wait access), captured copies otherwise.
    always_comb begin
        busy = (state != ST_IDLE);
        if (state == ST_IDLE) begin
            acc_idx = addr_dm[ADDR_W+1:2];
            acc_wd  = wd_dm;
            acc_we  = we_dm;
        end else begin
            acc_idx = idx_q;
            acc_wd  = wd_q;
            acc_we  = we_q;
        end
    end

endmodule

// File: tb/tb_nf_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_nf_dm_responder
//   Bench for nf_dm_responder. Two instances: dut (WAIT_CYCLES=2) and dut0
//   (WAIT_CYCLES=0). Stimulus pushes the expected ack cycle and load data into
//   a per-instance queue; monitors pop and compare whenever an ack appears.
// -----------------------------------------------------------------------------
module tb_nf_dm_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic        we = 1'b0;
    logic        req = 1'b0;
    logic [31:0] rd;
    logic        ack;
    logic        busy;

    logic [31:0] addr0 = '0;
    logic [31:0] wd0 = '0;
    logic        we0 = 1'b0;
    logic        req0 = 1'b0;
    logic [31:0] rd0;
    logic        ack0;
    logic        busy0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        bit          is_load;
        logic [31:0] data;
        int          ack_cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t sbq0[$];
    exp_t mon_e;
    exp_t mon_e0;

    nf_dm_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .addr_dm(addr), .wd_dm(wd), .we_dm(we),
        .req_dm(req), .rd_dm(rd), .req_ack_dm(ack), .busy(busy)
    );

    nf_dm_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .addr_dm(addr0), .wd_dm(wd0), .we_dm(we0),
        .req_dm(req0), .rd_dm(rd0), .req_ack_dm(ack0), .busy(busy0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Advance to just after the n-th following rising edge.
    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one request on the selected instance, record its expectation,
    // hold req until the ack shows, then release it in the following cycle.
    task automatic applyStimulus(input bit sel, input bit w,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] exp_data);
        exp_t e;
        int   n;
        e.is_load = !w;
        e.data    = exp_data;
        if (sel) begin
            e.ack_cyc = cyc + 1;
            sbq0.push_back(e);
            addr0 = a; wd0 = d; we0 = w; req0 = 1'b1;
        end else begin
            e.ack_cyc = cyc + 3;
            sbq.push_back(e);
            addr = a; wd = d; we = w; req = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? ack0 : ack) && n < 20);
        if (!(sel ? ack0 : ack)) checkOutput("ack_timeout", 32'd0, 32'd1);
        stepCycles(1);
        if (sel) begin req0 = 1'b0; we0 = 1'b0; end
        else begin req = 1'b0; we = 1'b0; end
    endtask

    // Monitor for dut: every ack must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && ack) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                checkOutput("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
                if (mon_e.is_load) checkOutput("load_data", rd, mon_e.data);
            end
        end
    end

    // Monitor for dut0.
    always @(negedge clk) begin
        if (!reset && ack0) begin
            if (sbq0.size() == 0) begin
                checkOutput("unexpected_ack0", 32'd1, 32'd0);
            end else begin
                mon_e0 = sbq0.pop_front();
                checkOutput("ack0_cycle", 32'(cyc), 32'(mon_e0.ack_cyc));
                if (mon_e0.is_load) checkOutput("load0_data", rd0, mon_e0.data);
            end
        end
    end

    initial begin
        exp_t e;
        int   n;

        // Reset state
        stepCycles(3);
        checkOutput("reset_ack", {31'd0, ack}, 32'd0);
        checkOutput("reset_rd", rd, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_rd0", rd0, 32'd0);
        reset = 1'b0;
        stepCycles(2);

        // Store then load, ack three cycles after request, load data held
        $display("[TB] store/load with two wait states");
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            checkOutput("rd_hold", rd, 32'hDEADBEEF);
            stepCycles(1);
        end
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        // Zero wait states, back-to-back loads with req held continuously
        $display("[TB] zero wait states, back-to-back");
        applyStimulus(1, 1'b1, 32'h4, 32'h44444444, 32'h0);
        applyStimulus(1, 1'b1, 32'h8, 32'h88888888, 32'h0);
        applyStimulus(1, 1'b1, 32'hC, 32'hCCCCCCCC, 32'h0);
        stepCycles(1);
        e.is_load = 1'b1;
        e.data = 32'h44444444; e.ack_cyc = cyc + 1; sbq0.push_back(e);
        e.data = 32'h88888888; e.ack_cyc = cyc + 3; sbq0.push_back(e);
        e.data = 32'hCCCCCCCC; e.ack_cyc = cyc + 5; sbq0.push_back(e);
        addr0 = 32'h4; we0 = 1'b0; req0 = 1'b1;
        stepCycles(2);
        addr0 = 32'h8;
        stepCycles(2);
        addr0 = 32'hC;
        stepCycles(2);
        req0 = 1'b0;
        stepCycles(2);

        // Abort in WAIT: no store, no ack, busy clears next cycle
        $display("[TB] abort during wait");
        applyStimulus(0, 1'b1, 32'h20, 32'h0, 32'h0);
        addr = 32'h20; wd = 32'h12345678; we = 1'b1; req = 1'b1;
        stepCycles(1);
        checkOutput("abort_busy_wait", {31'd0, busy}, 32'd1);
        req = 1'b0; we = 1'b0;
        stepCycles(1);
        checkOutput("abort_busy_idle", {31'd0, busy}, 32'd0);
        stepCycles(3);
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 32'h0);

        // Aliasing above the index and ignored byte offset
        $display("[TB] address aliasing");
        applyStimulus(0, 1'b1, 32'h0000_1008, 32'hA5A5A5A5, 32'h0);
        applyStimulus(0, 1'b0, 32'h0000_0008, 32'h0, 32'hA5A5A5A5);
        applyStimulus(0, 1'b0, 32'h0000_000B, 32'h0, 32'hA5A5A5A5);

        // Reset in the middle of a store
        $display("[TB] reset during wait");
        applyStimulus(0, 1'b1, 32'h30, 32'h11111111, 32'h0);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 32'hA5A5A5A5);
        addr = 32'h30; wd = 32'hCAFEF00D; we = 1'b1; req = 1'b1;
        stepCycles(1);
        reset = 1'b1; req = 1'b0; we = 1'b0;
        stepCycles(1);
        checkOutput("rst_mid_ack", {31'd0, ack}, 32'd0);
        checkOutput("rst_mid_rd", rd, 32'd0);
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        stepCycles(2);
        applyStimulus(0, 1'b0, 32'h30, 32'h0, 32'h11111111);

        // Inputs changing after accept are ignored
        $display("[TB] input change during wait");
        applyStimulus(0, 1'b1, 32'h40, 32'h0BADF00D, 32'h0);
        applyStimulus(0, 1'b1, 32'h44, 32'h600DCAFE, 32'h0);
        e.is_load = 1'b1; e.data = 32'h0BADF00D; e.ack_cyc = cyc + 3;
        sbq.push_back(e);
        addr = 32'h40; wd = 32'h0; we = 1'b0; req = 1'b1;
        stepCycles(1);
        addr = 32'h44; wd = 32'hDEADDEAD; we = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 20);
        if (!ack) checkOutput("ack_timeout", 32'd0, 32'd1);
        stepCycles(1);
        req = 1'b0; we = 1'b0;
        stepCycles(1);
        applyStimulus(0, 1'b0, 32'h44, 32'h0, 32'h600DCAFE);
        applyStimulus(0, 1'b0, 32'h40, 32'h0, 32'h0BADF00D);

        stepCycles(4);
        checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
        checkOutput("sb0_drained", 32'(sbq0.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
